// File: rtl/manual_vector_entry_pkg.sv
// Shared constants for the manual vector entry block: FSM encoding and
// default sizing.
package manual_vector_entry_pkg;

  localparam logic ST_COLLECT = 1'b0;
  localparam logic ST_FULL    = 1'b1;

  localparam int DEFAULT_WIDTH           = 8;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 250000;

  typedef enum logic {
    COLLECT = ST_COLLECT,
    FULL    = ST_FULL
  } state_e;

endpackage

// File: rtl/manual_vector_entry_if.sv
// Button inputs and vector/status outputs of the manual vector entry block.
interface manual_vector_entry_if
  import manual_vector_entry_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             btn_zero;
  logic             btn_one;
  logic             btn_clear;
  logic [WIDTH-1:0] vector;
  logic [CNT_W-1:0] count;
  logic             vector_valid;
  logic             done;
  logic             error;

  modport master (
    output btn_zero, btn_one, btn_clear,
    input  vector, count, vector_valid, done, error
  );

  modport slave (
    input  btn_zero, btn_one, btn_clear,
    output vector, count, vector_valid, done, error
  );

endinterface

// File: rtl/manual_vector_entry_button_debounce.sv
// One raw button: 2-flop synchronizer, counter debouncer and a one-cycle
// press pulse on the debounced rising edge.
module button_debounce
  import manual_vector_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_p0_q, sync_p0_d;
  logic             sync_p1_q, sync_p1_d;
  logic             stable_q, stable_d;
  logic             stable_prev_q, stable_prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sync_p0_d     = raw;
    sync_p1_d     = sync_p0_q;
    stable_d      = stable_q;
    stable_prev_d = stable_q;
    cnt_d         = '0;
    // Stage boundary: synchronized level feeds the debounce counter
    if (sync_p1_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync_p1_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_p0_q     <= 1'b0;
      sync_p1_q     <= 1'b0;
      stable_q      <= 1'b0;
      stable_prev_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      sync_p0_q     <= sync_p0_d;
      sync_p1_q     <= sync_p1_d;
      stable_q      <= stable_d;
      stable_prev_q <= stable_prev_d;
      cnt_q         <= cnt_d;
    end
  end

  assign level = stable_q;
  assign press = stable_q & ~stable_prev_q;

endmodule

// File: rtl/manual_vector_entry.sv
// Collects debounced "0"/"1" button presses LSB-first into a WIDTH-bit
// vector and flags completion; "clear" restarts entry.
module manual_vector_entry
  import manual_vector_entry_pkg::*;
#(
  parameter int WIDTH           = DEFAULT_WIDTH,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  manual_vector_entry_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [2:0] levels_unused;
  logic       press_zero, press_one, press_clear;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_zero (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (bus.btn_zero),
    .level (levels_unused[0]),
    .press (press_zero)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_one (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (bus.btn_one),
    .level (levels_unused[1]),
    .press (press_one)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (bus.btn_clear),
    .level (levels_unused[2]),
    .press (press_clear)
  );

  state_e           state_q, state_d;
  logic [WIDTH-1:0] vector_q, vector_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;
  logic             error_q, error_d;

  always_comb begin
    state_d  = state_q;
    vector_d = vector_q;
    count_d  = count_q;
    done_d   = 1'b0;
    error_d  = 1'b0;
    // Stage boundary: press pulses drive the entry FSM
    if (press_clear) begin
      state_d  = COLLECT;
      vector_d = '0;
      count_d  = '0;
    end else if (state_q == COLLECT) begin
      if (press_zero && press_one) begin
        error_d = 1'b1;
      end else if (press_zero || press_one) begin
        for (int i = 0; i < WIDTH; i++) begin
          if (count_q == CNT_W'(i)) vector_d[i] = press_one;
        end
        count_d = count_q + CNT_W'(1);
        if (count_q == CNT_W'(WIDTH - 1)) begin
          state_d = FULL;
          done_d  = 1'b1;
        end
      end
    end
    valid_d = (state_d == FULL);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= COLLECT;
      vector_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      vector_q <= vector_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      error_q  <= error_d;
    end
  end

  assign bus.vector       = vector_q;
  assign bus.count        = count_q;
  assign bus.vector_valid = valid_q;
  assign bus.done         = done_q;
  assign bus.error        = error_q;

endmodule

// File: doc/manual_vector_entry.md
# manual_vector_entry

Input-side companion to the manual LED test harnesses. An engineer enters a WIDTH-bit test vector on the board by pressing three buttons: "0", "1" and "clear". The block synchronizes and debounces each raw button and shifts the entered bits into a vector, LSB first. It presents the finished vector to a combinational chip under test (Or8Way, And16, ...) and reports completion, so test inputs come from the bench instead of hard-wired constants.

## Interface

Parameters:
- WIDTH, 8: vector length in bits.
- DEBOUNCE_CYCLES, 250000: consecutive stable clock cycles required to accept a button level change; minimum 1.

Ports:
- clk  input  1  sole clock; all state updates on its rising edge.
- rst_n  input  1  reset, synchronous and active-low.
- btn_zero  input  1  raw, asynchronous, active-high "enter 0" button.
- btn_one  input  1  raw, asynchronous, active-high "enter 1" button.
- btn_clear  input  1  raw, asynchronous, active-high "clear" button.
- vector  output  WIDTH  entered bits; bit i is the (i+1)-th accepted press.
- count  output  $clog2(WIDTH+1)  number of bits entered, 0..WIDTH.
- vector_valid  output  1  high while the state is FULL.
- done  output  1  one-cycle pulse on the entry that fills the vector.
- error  output  1  one-cycle pulse when "0" and "1" presses coincide in COLLECT.

## Operation

- Each button passes through a 2-flop synchronizer, then a debouncer.
  - The debouncer holds a `stable` level and a counter.
  - The counter clears on every edge where the synchronized level equals `stable`, and increments otherwise.
  - `stable` takes the synchronized level on the DEBOUNCE_CYCLES-th consecutive differing edge; the counter clears at the same edge.
  - A press event is `stable & ~stable_d`, one cycle wide. Release produces no event.
- FSM states: COLLECT (reset state) and FULL.
- COLLECT, single bit press (zero xor one): `vector[count]` <= pressed value; count <= count+1.
  - If count was WIDTH-1, go to FULL and pulse done on that same edge.
- COLLECT, both bit presses in the same cycle: no vector/count change; pulse error.
- FULL: bit presses are ignored. vector, count and vector_valid hold; error never fires.
- Clear press in any state: vector <= 0, count <= 0, state <= COLLECT. Clear wins over any simultaneous bit press, and no error or done fires.
- Unwritten vector bits read 0.

## Timing

- Reset (rst_n low at an edge) forces every register to 0: synchronizers, stable, stable_d, counters, vector, count, done, error, vector_valid; state becomes COLLECT.
  - Reset mid-entry discards partial data.
  - A button held through reset release is seen as a fresh press once debounced.
- Latency from a raw button rising and held steady before edge E to the vector/count/done/error update: edge E+DEBOUNCE_CYCLES+2, i.e. DEBOUNCE_CYCLES+3 edges inclusive of E.
- vector_valid rises on the same edge as the done pulse. It falls on the edge that applies the clear.
- Glitches shorter than DEBOUNCE_CYCLES cycles produce no event.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure

- The shared package holds the FSM state localparams (ST_COLLECT=1'b0, ST_FULL=1'b1) and the default DEBOUNCE_CYCLES constant.
- Sub-module `button_debounce` (parameter DEBOUNCE_CYCLES; ports clk, rst_n, raw, level, press) contains synchronizer, debouncer and edge detect. It is instantiated three times.
- The top level holds the FSM, the vector/count registers and the output pulses.

## Test plan

All scenarios use DEBOUNCE_CYCLES=4 and WIDTH=8.
- Press "1" then seven "0" presses -> vector=8'h01, count=8, vector_valid=1, exactly one done pulse, coinciding with the eighth update.
- Seven "0" presses then "1" -> vector=8'h80. Then press "1" twice more -> vector stays 8'h80 and count stays 8.
- Hold btn_one raw high 3 cycles, low 3, high 3, then low -> no event, count=0. Holding it high steadily from edge E -> count=1 at edge E+6.
- Enter 5 bits, then press "1" and "clear" in the same cycle -> vector=0, count=0, no error. Press "0" and "1" in the same cycle -> one error pulse, count unchanged.
- With count=5, drive rst_n low for one edge -> all outputs 0 at that edge. btn_zero held through reset -> count=1 six edges after reset release.
